// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and fixed addresses/sizes.
package nes_pkg;

    // OAM DMA controller states
    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // CPU register address that starts a sprite DMA
    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

    // Number of bytes in PPU OAM
    localparam int OAM_SIZE = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: on a CPU write to the DMA register, halts the CPU and copies
// one page of CPU memory into PPU OAM. Each byte takes a READ cycle followed by
// a WRITE cycle. An optional alignment cycle is inserted when the trigger lands
// on an odd cycle.
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
    parameter int          N_BYTES      = OAM_SIZE,     // power of 2, at most 256
    parameter bit          ODD_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        nres_in,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        oam_dma,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        oam_we
);

    // Index of the final byte of a transfer; idx never wraps within a transfer
    localparam logic [7:0] LAST_IDX = 8'(N_BYTES - 1);

    dma_state_t state_reg, state_next;
    logic [7:0] page_reg, page_next;
    logic [7:0] idx_reg, idx_next;
    logic       align_reg, align_next;
    logic       parity_reg;

    logic trigger;

    // The trigger is only honoured while idle; retriggers during a transfer are dropped
    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

    // Free-running cycle parity, used to decide whether an alignment cycle is needed
    always_ff @(posedge clk or negedge nres_in) begin
        if (!nres_in) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ~parity_reg;
        end
    end

    // State, page, index and alignment-flag registers
    always_ff @(posedge clk or negedge nres_in) begin
        if (!nres_in) begin
            state_reg <= DMA_IDLE;
            page_reg  <= 8'h00;
            idx_reg   <= 8'h00;
            align_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            page_reg  <= page_next;
            idx_reg   <= idx_next;
            align_reg <= align_next;
        end
    end

    // Next-state logic: HALT gives the CPU one cycle to finish its write,
    // then optional ALIGN, then READ/WRITE pairs until the last index
    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        idx_next   = idx_reg;
        align_next = align_reg;
        case (state_reg)
            DMA_IDLE: begin
                if (trigger) begin
                    page_next  = cpu_data_out;
                    idx_next   = 8'h00;
                    align_next = ODD_ALIGN && parity_reg;
                    state_next = DMA_HALT;
                end
            end
            DMA_HALT: begin
                state_next = align_reg ? DMA_ALIGN : DMA_READ;
            end
            DMA_ALIGN: begin
                state_next = DMA_READ;
            end
            DMA_READ: begin
                state_next = DMA_WRITE;
            end
            DMA_WRITE: begin
                if (idx_reg == LAST_IDX) begin
                    idx_next   = 8'h00;
                    state_next = DMA_IDLE;
                end else begin
                    idx_next   = idx_reg + 8'h01;
                    state_next = DMA_READ;
                end
            end
            default: begin
                state_next = DMA_IDLE;
                idx_next   = 8'h00;
            end
        endcase
    end

    // Moore outputs decoded from the state register; read data passes straight
    // through to OAM during WRITE since memory returns it one cycle after READ
    always_comb begin
        oam_dma     = (state_reg != DMA_IDLE);
        mem_rd      = 1'b0;
        mem_addr    = 16'h0000;
        oam_we      = 1'b0;
        oam_addr    = 8'h00;
        oam_data_in = 8'h00;
        case (state_reg)
            DMA_READ: begin
                mem_rd   = 1'b1;
                mem_addr = {page_reg, idx_reg};
            end
            DMA_WRITE: begin
                oam_we      = 1'b1;
                oam_addr    = idx_reg;
                oam_data_in = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- CPU-side OAM DMA engine. A CPU write to the DMA register ($4014) holds a page number. The engine then halts the CPU, reads CPU memory page {page,00}..{page,FF}, and writes each byte into PPU OAM slots 0..255.
- It is the bus initiator that drives the PPU OAM write port (oam_addr, oam_data_in, oam_we).
- It also supplies the oam_dma halt request that the top level folds into CPU rdy.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- N_BYTES, 256, bytes per transfer; must be a power of 2, at most 256.
- ODD_ALIGN, 1, when 1 insert one alignment cycle if the trigger lands on an odd cycle.

Ports:
- clk  input  1  system clock.
- nres_in  input  1  asynchronous, active-low reset.
- cpu_addr  input  16  CPU address bus.
- cpu_data_out  input  8  CPU write data.
- cpu_we  input  1  CPU write strobe, one cycle per write.
- mem_rdata  input  8  CPU-memory read data, valid the cycle after mem_rd.
- oam_dma  output  1  DMA active; top level drives rdy = ~oam_dma.
- mem_addr  output  16  DMA read address into CPU memory.
- mem_rd  output  1  DMA read strobe.
- oam_addr  output  8  OAM write index.
- oam_data_in  output  8  OAM write data.
- oam_we  output  1  OAM write enable.

Behaviour:
- Reset (nres_in low, async):
  - state=IDLE, page=0, idx=0, parity=0.
  - All outputs 0: oam_dma, mem_rd, oam_we, mem_addr, oam_addr, oam_data_in.
- parity: free-running flop, toggles every clk after reset.
- Trigger: in IDLE, cpu_we && cpu_addr==DMA_REG_ADDR at edge E0:
  - page<=cpu_data_out, idx<=0, state<=HALT.
  - If ODD_ALIGN && parity==1 at E0, set align flag.
- States (all registered, Moore outputs):
  - IDLE: oam_dma=0. Waits for trigger.
  - HALT: oam_dma=1, no bus activity. One cycle; this lets the CPU finish its write. Next state is ALIGN if align flag is set, else READ.
  - ALIGN: oam_dma=1, idle. One cycle, then READ.
  - READ: oam_dma=1, mem_rd=1, mem_addr={page,idx}. Next state WRITE.
  - WRITE: oam_dma=1, oam_we=1, oam_addr=idx, oam_data_in=mem_rdata (combinational pass-through of the previous cycle's read).
    - If idx==N_BYTES-1: go to IDLE, idx<=0.
    - Else: idx<=idx+1, go to READ.
- Timing:
  - oam_dma is high for exactly 1+2*N_BYTES cycles (513), or 2+2*N_BYTES (514) when aligned. It starts the cycle after E0.
  - oam_dma drops in the cycle after the final WRITE.
- Width rules:
  - idx is 8 bits and does not wrap within a transfer.
  - mem_addr high byte is always page; no carry into page.
- Boundary conditions:
  - Trigger writes while oam_dma=1 are ignored; page is not reloaded.
  - Writes to any other address have no effect in any state.
  - A trigger in the same cycle the FSM returns to IDLE is not accepted. The trigger is sampled only when state==IDLE at the edge.
  - Back-to-back: a trigger in the first IDLE cycle after completion starts a new transfer normally.
  - Reset mid-transfer: immediately IDLE, all outputs 0, no partial OAM write after release. OAM contents already written are kept; they are not this block's state.
  - mem_rd and oam_we are never asserted in the same cycle.
  - In IDLE, mem_addr and oam_addr hold 0.

Decomposition:
- Shared package nes_pkg holds:
  - typedef enum logic [2:0] dma_state_t {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE}.
  - Constant OAM_DMA_ADDR = 16'h4014.
  - Constant OAM_SIZE = 256.
- No sub-module. The parity flop and index counter stay inline; the block is a single FSM with a datapath.

Test Plan:
- Even-cycle trigger: cpu_we, addr 4014, data 02, parity 0.
  - oam_dma high 513 cycles.
  - mem_addr steps 0200..02FF on READ cycles.
  - Memory preloaded with byte = low address XOR A5; OAM[i] == i^A5 for all 256 slots; oam_we pulses exactly 256 times.
- Odd-cycle trigger, page 07: oam_dma high 514 cycles; first mem_rd appears 3 cycles after E0 (vs 2 for even).
- Retrigger and stray writes: during an active DMA, write 4014=03, then write 4013=FF and 2004=11.
  - Page stays 07; mem_addr never leaves 07xx.
  - Exactly 256 writes occur.
- Reset mid-transfer: assert nres_in low at idx=0x40 in WRITE.
  - oam_dma, oam_we and mem_rd go 0 asynchronously.
  - After release no oam_we until a new trigger; a new trigger with page 01 completes normally with 256 writes.
- Back-to-back: second trigger (page 05) in the first IDLE cycle after completion is accepted. Second trigger in the completion cycle itself is ignored.
- Ordering check (assertion): mem_rd && oam_we is never true in the same cycle. Each oam_we is preceded exactly one cycle by mem_rd with mem_addr low byte == oam_addr.
